// File: rtl/bram_pkg.sv
// bram_pkg: write-mode encodings and a configuration check shared by the dual-port RAM.
package bram_pkg;
    localparam int MODE_WRITE_FIRST = 0;
    localparam int MODE_READ_FIRST  = 1;
    localparam int MODE_NO_CHANGE   = 2;

    function automatic bit mode_ok(input int mode);
        return mode >= MODE_WRITE_FIRST && mode <= MODE_NO_CHANGE;
    endfunction
endpackage

// File: rtl/bram_dp_param_if.sv
// bram_dp_param_if: both RAM ports plus the collision flag, bundled for the RAM and its user.
interface bram_dp_param_if #(
    parameter int DATA_W = 8,
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 11
);
    localparam int NB = DATA_W / BYTE_W;
    logic              ena, enb, ssra, ssrb, collision;
    logic [NB-1:0]     wea, web;
    logic [ADDR_W-1:0] addra, addrb;
    logic [DATA_W-1:0] dia, dib, doa, dob;

    modport master (
        output ena, wea, addra, dia, ssra, enb, web, addrb, dib, ssrb,
        input  doa, dob, collision
    );
    modport slave (
        input  ena, wea, addra, dia, ssra, enb, web, addrb, dib, ssrb,
        output doa, dob, collision
    );
endinterface

// File: rtl/bram_port_out.sv
// bram_port_out: per-port output path -- write-mode select, sync set/reset, optional output register.
module bram_port_out
    import bram_pkg::*;
#(
    parameter int              DATA_W = 8,
    parameter int              MODE   = MODE_WRITE_FIRST,
    parameter int              OREG   = 0,
    parameter logic [DATA_W-1:0] SRVAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              wr,
    input  logic              ssr,
    input  logic [DATA_W-1:0] old,
    input  logic [DATA_W-1:0] merged,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] s1, s2, sel;
    logic              load;

    assign sel  = (wr && MODE == MODE_WRITE_FIRST) ? merged : old;
    assign load = en && !(wr && MODE == MODE_NO_CHANGE);

    // ssr targets whichever stage drives dout; stage 1 keeps reading when a second stage exists
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= SRVAL;
            s2 <= SRVAL;
        end else begin
            if (en && ssr && OREG == 0) s1 <= SRVAL;
            else if (load)              s1 <= sel;
            s2 <= (en && ssr) ? SRVAL : s1;
        end
    end

    assign dout = (OREG != 0) ? s2 : s1;
endmodule

// File: rtl/bram_dp_param.sv
// bram_dp_param: single-clock true dual-port RAM with byte enables, per-port write mode,
// set/reset values, optional output register and same-address collision flag.
module bram_dp_param
    import bram_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                BYTE_W   = 8,
    parameter int                ADDR_W   = 11,
    parameter int                MODE_A   = MODE_WRITE_FIRST,
    parameter int                MODE_B   = MODE_WRITE_FIRST,
    parameter int                OREG_A   = 0,
    parameter int                OREG_B   = 0,
    parameter logic [DATA_W-1:0] SRVAL_A  = '0,
    parameter logic [DATA_W-1:0] SRVAL_B  = '0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic             clock,
    input logic             reset,
    bram_dp_param_if.slave  bus
);
    localparam int NB = DATA_W / BYTE_W;

    if (DATA_W % BYTE_W != 0 || !mode_ok(MODE_A) || !mode_ok(MODE_B)) begin : g_bad_cfg
        $fatal(1, "bram_dp_param: DATA_W must be a multiple of BYTE_W and modes must be 0..2");
    end

    logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: INIT_VAL};
    logic [DATA_W-1:0] ra, rb, ma, mb;
    logic              coll;

    assign ra = mem[bus.addra];
    assign rb = mem[bus.addrb];

    always_comb begin
        ma = ra;
        mb = rb;
        for (int i = 0; i < NB; i++) begin
            if (bus.wea[i]) ma[i*BYTE_W +: BYTE_W] = bus.dia[i*BYTE_W +: BYTE_W];
            if (bus.web[i]) mb[i*BYTE_W +: BYTE_W] = bus.dib[i*BYTE_W +: BYTE_W];
        end
    end

    // port A lanes are written last so they win a same-address, same-lane conflict
    always_ff @(posedge clock) begin
        for (int i = 0; i < NB; i++) begin
            if (bus.enb && bus.web[i]) mem[bus.addrb][i*BYTE_W +: BYTE_W] <= bus.dib[i*BYTE_W +: BYTE_W];
            if (bus.ena && bus.wea[i]) mem[bus.addra][i*BYTE_W +: BYTE_W] <= bus.dia[i*BYTE_W +: BYTE_W];
        end
        coll <= reset ? 1'b0
              : bus.ena && bus.enb && bus.addra == bus.addrb && (|bus.wea || |bus.web);
    end

    assign bus.collision = coll;

    bram_port_out #(.DATA_W(DATA_W), .MODE(MODE_A), .OREG(OREG_A), .SRVAL(SRVAL_A)) u_out_a (
        .clock(clock), .reset(reset), .en(bus.ena), .wr(|bus.wea), .ssr(bus.ssra),
        .old(ra), .merged(ma), .dout(bus.doa)
    );

    bram_port_out #(.DATA_W(DATA_W), .MODE(MODE_B), .OREG(OREG_B), .SRVAL(SRVAL_B)) u_out_b (
        .clock(clock), .reset(reset), .en(bus.enb), .wr(|bus.web), .ssr(bus.ssrb),
        .old(rb), .merged(mb), .dout(bus.dob)
    );
endmodule

// File: tb/tb_bram_dp_param.sv
// tb_bram_dp_param: directed scoreboard bench; u0 = 8b default RAM (B READ_FIRST),
// u1 = 32b RAM with A NO_CHANGE and B output-registered with SRVAL 5A.
module tb_bram_dp_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    bram_dp_param_if #(.DATA_W(8), .BYTE_W(8), .ADDR_W(11)) i0 ();
    bram_dp_param_if #(.DATA_W(32), .BYTE_W(8), .ADDR_W(4)) i1 ();

    bram_dp_param #(.MODE_B(1)) u0 (.clock(clk), .reset(rst), .bus(i0));
    bram_dp_param #(
        .DATA_W(32), .BYTE_W(8), .ADDR_W(4), .MODE_A(2), .OREG_B(1), .SRVAL_B(32'h5A)
    ) u1 (.clock(clk), .reset(rst), .bus(i1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [31:0] v);
        sb.push_back('{t, v});
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h with no expected value queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic a0(input logic e, input logic w, input logic [10:0] ad, input logic [7:0] d, input logic s);
        i0.ena = e; i0.wea = w; i0.addra = ad; i0.dia = d; i0.ssra = s;
    endtask

    task automatic b0(input logic e, input logic w, input logic [10:0] ad, input logic [7:0] d, input logic s);
        i0.enb = e; i0.web = w; i0.addrb = ad; i0.dib = d; i0.ssrb = s;
    endtask

    task automatic a1(input logic e, input logic [3:0] w, input logic [3:0] ad, input logic [31:0] d, input logic s);
        i1.ena = e; i1.wea = w; i1.addra = ad; i1.dia = d; i1.ssra = s;
    endtask

    task automatic b1(input logic e, input logic [3:0] w, input logic [3:0] ad, input logic [31:0] d, input logic s);
        i1.enb = e; i1.web = w; i1.addrb = ad; i1.dib = d; i1.ssrb = s;
    endtask

    initial begin
        a0(0, 0, 0, 0, 0); b0(0, 0, 0, 0, 0);
        a1(0, 0, 0, 0, 0); b1(0, 0, 0, 0, 0);
        rst = 1'b1;
        push("rst_doa0", 'h00); push("rst_dob0", 'h00); push("rst_coll0", 0);
        push("rst_doa1", 'h00); push("rst_dob1", 'h5A);
        tick();
        chk(32'(i0.doa)); chk(32'(i0.dob)); chk(32'(i0.collision));
        chk(i1.doa); chk(i1.dob);
        rst = 1'b0;

        // default write on both ports, then read back
        a0(1, 1, 0, 'hF3, 0); b0(1, 1, 1, 'hA5, 0);
        push("wf_doa", 'hF3); push("rf_dob_init", 'h00);
        tick();
        chk(32'(i0.doa)); chk(32'(i0.dob));
        a0(1, 0, 0, 0, 0); b0(1, 0, 1, 0, 0);
        push("rd_doa", 'hF3); push("rd_dob", 'hA5); push("coll_diff_addr", 0);
        tick();
        chk(32'(i0.doa)); chk(32'(i0.dob)); chk(32'(i0.collision));

        // WRITE_FIRST on u0.A, READ_FIRST on u0.B
        a0(1, 1, 5, 'h11, 0); b0(1, 1, 6, 'h11, 0);
        tick();
        a0(1, 1, 5, 'h22, 0); b0(1, 1, 6, 'h22, 0);
        push("mode_wf", 'h22); push("mode_rf", 'h11);
        tick();
        chk(32'(i0.doa)); chk(32'(i0.dob));
        a0(1, 0, 5, 0, 0); b0(1, 0, 6, 0, 0);
        push("wf_mem", 'h22); push("rf_mem", 'h22);
        tick();
        chk(32'(i0.doa)); chk(32'(i0.dob));

        // NO_CHANGE on u1.A
        a1(1, 4'hF, 5, 'h11, 0);
        push("nc_hold_rst", 'h0);
        tick();
        chk(i1.doa);
        a1(1, 0, 5, 0, 0);
        push("nc_read11", 'h11);
        tick();
        chk(i1.doa);
        a1(1, 4'hF, 5, 'h22, 0);
        push("mode_nc", 'h11);
        tick();
        chk(i1.doa);
        a1(1, 0, 5, 0, 0);
        push("nc_mem", 'h22);
        tick();
        chk(i1.doa);

        // byte lanes on the 32b instance
        a1(1, 4'hF, 0, 'hAABBCCDD, 0);
        tick();
        a1(1, 4'b0101, 0, 'h11223344, 0);
        tick();
        a1(1, 0, 0, 0, 0);
        push("byte_merge", 'hAA22CC44);
        tick();
        chk(i1.doa);
        a1(0, 0, 0, 0, 0);

        // collisions on u0
        a0(1, 1, 7, 'h3C, 0); b0(1, 1, 7, 'hC3, 0);
        push("coll_ww_doa", 'h3C); push("coll_ww_dob_old", 'h00); push("coll_ww_flag", 1);
        tick();
        chk(32'(i0.doa)); chk(32'(i0.dob)); chk(32'(i0.collision));
        a0(0, 0, 0, 0, 0); b0(0, 0, 0, 0, 0);
        push("coll_ww_clear", 0);
        tick();
        chk(32'(i0.collision));
        a0(1, 0, 7, 0, 0); b0(1, 0, 7, 0, 0);
        push("coll_a_wins_a", 'h3C); push("coll_a_wins_b", 'h3C); push("coll_rr_none", 0);
        tick();
        chk(32'(i0.doa)); chk(32'(i0.dob)); chk(32'(i0.collision));
        a0(1, 1, 7, 'h55, 0); b0(1, 0, 7, 0, 0);
        push("coll_wr_doa", 'h55); push("coll_wr_dob_old", 'h3C); push("coll_wr_flag", 1);
        tick();
        chk(32'(i0.doa)); chk(32'(i0.dob)); chk(32'(i0.collision));
        a0(0, 0, 0, 0, 0); b0(0, 0, 0, 0, 0);
        push("coll_wr_clear", 0);
        tick();
        chk(32'(i0.collision));

        // output register + ssr + reset on u1.B
        a1(1, 4'hF, 1, 'hF3, 0);
        tick();
        a1(0, 0, 0, 0, 0); b1(1, 0, 1, 0, 0);
        push("oreg_lat1", 'h5A);
        tick();
        chk(i1.dob);
        b1(0, 0, 0, 0, 0);
        push("oreg_lat2", 'hF3);
        tick();
        chk(i1.dob);
        b1(1, 0, 1, 0, 1);
        push("oreg_ssr", 'h5A);
        tick();
        chk(i1.dob);
        b1(0, 0, 0, 0, 0);
        push("oreg_after_ssr", 'hF3);
        tick();
        chk(i1.dob);
        b1(1, 0, 0, 0, 0);
        rst = 1'b1;
        push("oreg_rst", 'h5A);
        tick();
        chk(i1.dob);
        rst = 1'b0;
        b1(0, 0, 0, 0, 0);
        push("oreg_no_stale1", 'h5A);
        tick();
        chk(i1.dob);
        push("oreg_no_stale2", 'h5A);
        tick();
        chk(i1.dob);

        // disabled ports ignore we and ssr
        a0(1, 0, 7, 0, 0); b0(1, 0, 7, 0, 0);
        push("pre_dis_doa", 'h55); push("pre_dis_dob", 'h55);
        tick();
        chk(32'(i0.doa)); chk(32'(i0.dob));
        a0(0, 1, 7, 'hAA, 1); b0(0, 1, 7, 'hBB, 1);
        push("dis_doa_hold", 'h55); push("dis_dob_hold", 'h55); push("dis_coll", 0);
        tick();
        chk(32'(i0.doa)); chk(32'(i0.dob)); chk(32'(i0.collision));
        a0(1, 0, 7, 0, 0); b0(0, 0, 0, 0, 0);
        push("dis_mem_kept", 'h55);
        tick();
        chk(32'(i0.doa));

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d queued expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
